// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests, holds one fetched slot for decode, handles redirects.
// Optional FETCH_MISALIGN_EN: misaligned fetch addresses raise an exception slot instead of being truncated.
module fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_ena,
    input  logic [31:0] trap_addr,
    input  logic        flush_EX,
    input  logic [31:0] jump_addr_EX,
    input  logic        jump_pred_IF,
    input  logic [31:0] jump_addr_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] PC_IF,
    output logic [31:0] IR_IF,
    output logic        fault_IF,
    output logic        misalign_IF
);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP, S_HALT} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, req_addr;
    logic        handoff, redirect, misaligned;
    logic [31:0] redir_tgt, next_pc, issue_addr;

    logic        load, load_mis, clr_valid, fpc_we, rq_we;
    logic [31:0] load_addr, fpc_d;

    always_comb begin
        handoff   = valid_out && ready_in;
        redirect  = trap_ena || flush_EX;
        redir_tgt = trap_ena ? trap_addr : jump_addr_EX;
        next_pc   = handoff ? (jump_pred_IF ? jump_addr_IF : PC_IF + 32'd4) : fetch_pc;
`ifdef FETCH_MISALIGN_EN
        issue_addr = next_pc;
        misaligned = |next_pc[1:0];
`else
        issue_addr = next_pc & ~32'h3;
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = req_addr;
        load      = 1'b0;
        load_mis  = 1'b0;
        load_addr = req_addr;
        clr_valid = 1'b0;
        fpc_we    = 1'b0;
        fpc_d     = redir_tgt;
        rq_we     = 1'b0;
        if (!reset) begin
            case (state)
                S_RUN: begin
                    if (redirect) begin
                        clr_valid = 1'b1;
                        fpc_we    = 1'b1;
                    end else if (!valid_out || handoff) begin
                        fpc_we = 1'b1;
                        fpc_d  = issue_addr;
                        if (misaligned) begin
                            load      = 1'b1;
                            load_mis  = 1'b1;
                            load_addr = issue_addr;
                            state_nx  = S_HALT;
                        end else begin
                            imem_req  = 1'b1;
                            imem_addr = issue_addr;
                            rq_we     = 1'b1;
                            if (imem_ack) begin
                                load      = 1'b1;
                                load_addr = issue_addr;
                                state_nx  = imem_err ? S_HALT : S_RUN;
                            end else begin
                                clr_valid = 1'b1;
                                state_nx  = S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        // A response arriving with the redirect is simply the one being dropped
                        clr_valid = 1'b1;
                        fpc_we    = 1'b1;
                        state_nx  = imem_ack ? S_RUN : S_DROP;
                    end else if (imem_ack) begin
                        load     = 1'b1;
                        state_nx = imem_err ? S_HALT : S_RUN;
                    end
                end
                S_DROP: begin
                    imem_req = 1'b1;
                    fpc_we   = redirect;
                    if (imem_ack) state_nx = S_RUN;
                end
                S_HALT: begin
                    if (redirect) begin
                        clr_valid = 1'b1;
                        fpc_we    = 1'b1;
                        state_nx  = S_RUN;
                    end else if (handoff) begin
                        clr_valid = 1'b1;
                    end
                end
                default: state_nx = S_RUN;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic mis_q;
    assign misalign_IF = mis_q;
    always_ff @(posedge clk) begin
        if (reset)          mis_q <= 1'b0;
        else if (load)      mis_q <= load_mis;
        else if (clr_valid) mis_q <= 1'b0;
    end
`else
    assign misalign_IF = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            valid_out <= 1'b0;
            fetch_pc  <= RESET_VEC;
            req_addr  <= RESET_VEC;
            PC_IF     <= 32'h0;
            IR_IF     <= NOP;
            fault_IF  <= 1'b0;
        end else begin
            state <= state_nx;
            if (fpc_we) fetch_pc <= fpc_d;
            if (rq_we)  req_addr <= issue_addr;
            if (load) begin
                valid_out <= 1'b1;
                PC_IF     <= load_addr;
                IR_IF     <= (load_mis || imem_err) ? NOP : imem_rdata;
                fault_IF  <= !load_mis && imem_err;
            end else if (clr_valid) begin
                valid_out <= 1'b0;
                fault_IF  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a program-order model predicts each delivered slot.
module tb_fetch_unit;
    localparam logic [31:0] RV  = 32'h00000100;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0, reset = 1'b1;
    logic trap_ena = 1'b0, flush_EX = 1'b0, jump_pred_IF = 1'b0, ready_in = 1'b0;
    logic [31:0] trap_addr = '0, jump_addr_EX = '0, jump_addr_IF = '0;
    logic imem_req, imem_ack = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic valid_out, fault_IF, misalign_IF;
    logic [31:0] PC_IF, IR_IF;

    fetch_unit #(.RESET_VEC(RV)) dut (
        .clk(clk), .reset(reset), .trap_ena(trap_ena), .trap_addr(trap_addr),
        .flush_EX(flush_EX), .jump_addr_EX(jump_addr_EX), .jump_pred_IF(jump_pred_IF),
        .jump_addr_IF(jump_addr_IF), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .valid_out(valid_out), .ready_in(ready_in), .PC_IF(PC_IF), .IR_IF(IR_IF),
        .fault_IF(fault_IF), .misalign_IF(misalign_IF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        fault;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    bit   halted = 1'b0, ack_always = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ ~a[15:0]};
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return a[7:2] == 6'h2A;
    endfunction

    // Expected slot contents for a fetch of address a
    function automatic exp_t entry(input logic [31:0] a);
        exp_t e;
        logic [31:0] aa;
        aa = a & ~32'h3;
        e.pc = aa; e.ir = is_err(aa) ? NOP : mem_word(aa); e.fault = is_err(aa); e.mis = 1'b0;
`ifdef FETCH_MISALIGN_EN
        if (a[1:0] != 2'b00) begin
            e.pc = a; e.ir = NOP; e.fault = 1'b0; e.mis = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 63) == 0) a = 32'hFFFF_FFFC;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the model by what those inputs mean
    task automatic step(input bit rst, input bit rdy, input bit tr, input logic [31:0] ta,
                        input bit fl, input logic [31:0] ea, input bit pr, input logic [31:0] pa);
        exp_t e;
        @(posedge clk); #1;
        reset = rst; ready_in = rdy; trap_ena = tr; trap_addr = ta;
        flush_EX = fl; jump_addr_EX = ea; jump_pred_IF = pr; jump_addr_IF = pa;
        if (rst) begin
            q.delete(); q.push_back(entry(RV)); halted = 1'b0;
        end else if (tr || fl) begin
            q.delete(); q.push_back(entry(tr ? ta : ea)); halted = 1'b0;
        end else if (valid_out && rdy && q.size() > 0) begin
            e = q[0];
            if (e.fault || e.mis) halted = 1'b1;
            else q.push_back(entry(pr ? pa : e.pc + 32'd4));
        end
    endtask

    // Memory responder: random latency, occasional stray acks when idle
    always begin
        @(posedge clk); #2;
        if (imem_req) begin
            imem_ack   = ack_always || ($urandom_range(0, 1) == 1);
            imem_rdata = mem_word(imem_addr);
            imem_err   = is_err(imem_addr);
        end else begin
            imem_ack   = ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            imem_err   = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    exp_t        me;
    bit          pend = 1'b0, hold = 1'b0;
    logic [31:0] pend_addr, hold_pc, hold_ir;
    int          idle = 0;
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0; hold = 1'b0; idle = 0;
        end else begin
            if (pend) begin
                chk("req_held", {31'b0, imem_req}, 32'd1);
                chk("addr_held", imem_addr, pend_addr);
            end
            if (hold) begin
                chk("stall_valid", {31'b0, valid_out}, 32'd1);
                chk("stall_pc", PC_IF, hold_pc);
                chk("stall_ir", IR_IF, hold_ir);
            end
            if (halted) chk("halt_no_req", {31'b0, imem_req}, 32'd0);
            if (valid_out && ready_in && !trap_ena && !flush_EX) begin
                if (q.size() == 0) begin
                    chk("spurious_slot_pc", PC_IF, 32'hxxxxxxxx);
                end else begin
                    me = q.pop_front();
                    chk("slot_pc", PC_IF, me.pc);
                    chk("slot_ir", IR_IF, me.ir);
                    chk("slot_fault", {31'b0, fault_IF}, {31'b0, me.fault});
                    chk("slot_misalign", {31'b0, misalign_IF}, {31'b0, me.mis});
                end
                idle = 0;
            end else if (trap_ena || flush_EX || q.size() == 0) begin
                idle = 0;
            end else begin
                idle++;
                if (idle >= 100) begin
                    chk("progress_idle", 32'(idle), 32'd0);
                    idle = 0;
                end
            end
            hold = valid_out && !ready_in && !trap_ena && !flush_EX;
            if (hold) begin
                chk("stall_no_req", {31'b0, imem_req}, 32'd0);
                hold_pc = PC_IF; hold_ir = IR_IF;
            end
            pend = imem_req && !imem_ack;
            pend_addr = imem_addr;
        end
    end

    initial begin
        bit          tr, fl;
        int          r;
        logic [31:0] exp_addr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", PC_IF, 32'h0);
        chk("rst_ir", IR_IF, NOP);
        chk("rst_fault", {31'b0, fault_IF}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_IF}, 32'd0);
        q.push_back(entry(RV));

        // Zero-latency memory, always ready: back-to-back sequential fetches
        ack_always = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            exp_addr = RV + 32'(4 * i);
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, exp_addr);
            chk("seq_valid", {31'b0, valid_out}, (i == 0) ? 32'd0 : 32'd1);
        end
        ack_always = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 39);
            tr = (r < 2);
            fl = (r >= 1 && r <= 3);
            step((i == 1500 || i == 1501), ($urandom_range(0, 3) != 0),
                 tr, rnd_addr(), fl, rnd_addr(),
                 ($urandom_range(0, 3) == 0), rnd_addr());
        end

        step(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VEC, default 32'h00000000, meaning first fetch address after reset.
REQ-002 Port clk, input, 1: rising-edge clock, sole clock.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port trap_ena, input, 1: trap entry/return redirect request.
REQ-005 Port trap_addr, input, 32: trap redirect target.
REQ-006 Port flush_EX, input, 1: EX mispredict redirect request.
REQ-007 Port jump_addr_EX, input, 32: EX redirect target.
REQ-008 Port jump_pred_IF, input, 1: predictor taken decision for PC_IF.
REQ-009 Port jump_addr_IF, input, 32: predicted target for PC_IF.
REQ-010 Port imem_req, output, 1: memory request.
REQ-011 Port imem_addr, output, 32: memory request address.
REQ-012 Port imem_ack, input, 1: response valid; may assert in the same cycle as imem_req.
REQ-013 Port imem_rdata, input, 32: instruction word, valid with imem_ack.
REQ-014 Port imem_err, input, 1: access fault, valid with imem_ack.
REQ-015 Port valid_out, output, 1: IF register holds an instruction.
REQ-016 Port ready_in, input, 1: downstream accepts the IF register this cycle.
REQ-017 Port PC_IF, output, 32: address of the held instruction.
REQ-018 Port IR_IF, output, 32: held instruction word.
REQ-019 Port fault_IF, output, 1: held slot is an access fault.
REQ-020 Port misalign_IF, output, 1: held slot is a misaligned-fetch exception.

Function
REQ-021 States SHALL be RUN (no request outstanding), WAIT (request outstanding), DROP (outstanding response to discard), HALT (fetch stopped after exception).
REQ-022 Handoff SHALL occur when valid_out && ready_in; redirect SHALL occur when trap_ena || flush_EX, with trap_ena taking priority over flush_EX.
REQ-023 In RUN, with no redirect, and with !valid_out || handoff, imem_req SHALL be 1 and the block SHALL enter WAIT.
REQ-024 Issue address: on handoff, jump_pred_IF ? jump_addr_IF : PC_IF+4 (mod 2^32); otherwise fetch_PC.
REQ-025 In WAIT and DROP, imem_req SHALL stay 1 and imem_addr SHALL stay equal to the issued address until imem_ack.
REQ-026 imem_ack in the issue cycle or in WAIT SHALL load PC_IF/IR_IF, set valid_out=1 next cycle, and enter RUN; peak throughput is one instruction per cycle.
REQ-027 imem_err with imem_ack SHALL load IR_IF=32'h00000013, set fault_IF=1, and enter HALT.
REQ-028 A redirect SHALL clear valid_out and set fetch_PC to the target next cycle; in RUN or HALT it enters RUN, and in WAIT it enters DROP.
REQ-029 Any handoff in the redirect cycle SHALL be ignored; the first request for the target SHALL issue no earlier than the cycle after the redirect.
REQ-030 In DROP, imem_ack SHALL be discarded (IF register unchanged) and the block SHALL enter RUN; a further redirect in DROP SHALL only update fetch_PC.
REQ-031 valid_out, PC_IF and IR_IF SHALL be held stable while valid_out && !ready_in.
REQ-032 imem_ack while in RUN or HALT with no request issued SHALL be ignored.
REQ-033 HALT SHALL issue no requests; after its slot is handed off valid_out=0, and exit is only by redirect.

Reset
REQ-034 Reset SHALL force state=RUN, valid_out=0, imem_req=0, fetch_PC=RESET_VEC, PC_IF=0, IR_IF=32'h00000013, fault_IF=0, misalign_IF=0; it overrides every other input.
REQ-035 Reset in WAIT or DROP SHALL abandon the request; the first request SHALL be RESET_VEC in the cycle after reset deasserts.

Configuration
REQ-036 With FETCH_MISALIGN_EN defined, an issue address with [1:0]!=0 SHALL issue no request; it SHALL load PC_IF=address, IR_IF=32'h00000013, misalign_IF=1, valid_out=1, and enter HALT.
REQ-037 Without FETCH_MISALIGN_EN, imem_addr[1:0] SHALL be forced to 2'b00 and misalign_IF SHALL be constant 0.

Verification
REQ-038 Reset with RESET_VEC=32'h100, zero-latency ack, ready_in=1 -> requests 0x100, 0x104, 0x108 on consecutive cycles; valid_out=1 from cycle 2.
REQ-039 PC_IF=0x200, jump_pred_IF=1, jump_addr_IF=0x340, handoff -> imem_addr=0x340 in the handoff cycle.
REQ-040 ready_in=0 for 3 cycles with valid_out=1 -> imem_req=0 and PC_IF/IR_IF unchanged throughout.
REQ-041 flush_EX=1, jump_addr_EX=0x500 in WAIT, ack 2 cycles later with 0xDEADBEEF -> word discarded; next request 0x500; valid_out never 1 for 0xDEADBEEF.
REQ-042 Simultaneous trap_ena (0x80) and flush_EX (0x500) -> next request 0x80.
REQ-043 imem_err on ack at 0x10, then trap_ena to 0x80 -> fault_IF=1 with IR_IF=0x00000013, no requests until trap, then request 0x80; with FETCH_MISALIGN_EN, jump_addr_IF=0x202 -> misalign_IF=1, PC_IF=0x202, no request.
